dsp_mac_multich: RTL and testbench



---
 rtl/dsp_pkg.sv | 29 ++
 rtl/dsp_sat_add.sv | 35 +++
 rtl/dsp_mac_multich.sv | 192 +++++++++++++++++++
 tb/tb_dsp_mac_multich.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - opmode encodings and saturation limits shared by the MAC slice
package dsp_pkg;

   // Accumulate operation carried in opmode[1:0]
   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ACC  = 2'b01,
      OP_SUB  = 2'b10,
      OP_CADD = 2'b11
   } acc_op_e;

   // Pre-adder control bits within opmode
   localparam int PREADD_EN  = 2;
   localparam int PREADD_SUB = 3;

   // Limits are built at this width and truncated by the caller
   localparam int LIMIT_W = 64;

   // Largest positive value of a w-bit two's-complement number
   function automatic logic [LIMIT_W-1:0] sat_max(input int w);
      return (LIMIT_W'(1) << (w - 1)) - LIMIT_W'(1);
   endfunction

   // Most negative value of a w-bit number (low w bits read 100..0)
   function automatic logic [LIMIT_W-1:0] sat_min(input int w);
      return LIMIT_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/dsp_sat_add.sv
// rtl/dsp_sat_add.sv - P_W+1 bit add/subtract with overflow detect and optional clamp
module dsp_sat_add
   import dsp_pkg::*;
#(
   parameter int P_W    = 48,
   parameter bit SAT_EN = 1'b1
)
(
   input  logic signed [P_W-1:0] op_a,
   input  logic signed [P_W-1:0] op_b,
   input  logic                  sub,
   output logic signed [P_W-1:0] res,
   output logic                  ovf
);

   localparam logic [P_W-1:0] P_MAX = P_W'(sat_max(P_W));
   localparam logic [P_W-1:0] P_MIN = P_W'(sat_min(P_W));

   logic signed [P_W:0] wide_a;
   logic signed [P_W:0] wide_b;
   logic signed [P_W:0] sum;

   // One guard bit exposes overflow; clamp toward the sign of the true result
   always_comb begin
      wide_a = (P_W+1)'(op_a);
      wide_b = (P_W+1)'(op_b);
      sum    = sub ? (wide_a - wide_b) : (wide_a + wide_b);
      ovf    = sum[P_W] ^ sum[P_W-1];
      res    = sum[P_W-1:0];
      if (ovf && SAT_EN) begin
         res = sum[P_W] ? P_MIN : P_MAX;
      end
   end

endmodule

// File: rtl/dsp_mac_multich.sv
// rtl/dsp_mac_multich.sv - 4-stage pre-add/multiply/accumulate slice with per-channel accumulators
module dsp_mac_multich
   import dsp_pkg::*;
#(
   parameter int A_W    = 18,
   parameter int B_W    = 18,
   parameter int C_W    = 48,
   parameter int P_W    = 48,
   parameter int NCH    = 4,
   parameter bit SAT_EN = 1'b1,
   localparam int CH_W  = $clog2(NCH)
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [CH_W-1:0]       in_ch,
   input  logic [3:0]            opmode,
   input  logic signed [A_W-1:0] a,
   input  logic signed [B_W-1:0] b,
   input  logic signed [B_W-1:0] d,
   input  logic signed [C_W-1:0] c,
   input  logic                  clr,
   output logic                  out_valid,
   output logic [CH_W-1:0]       out_ch,
   output logic signed [P_W-1:0] p,
   output logic                  ovf
);

   localparam int BP_W = B_W + 1;
   localparam int M_W  = A_W + B_W + 1;

   logic                  ch_ok;

   logic                  s1_valid;
   logic [CH_W-1:0]       s1_ch;
   logic [3:0]            s1_op;
   logic signed [A_W-1:0] s1_a;
   logic signed [B_W-1:0] s1_b;
   logic signed [B_W-1:0] s1_d;
   logic signed [C_W-1:0] s1_c;
   logic signed [BP_W-1:0] pre_sum;

   logic                  s2_valid;
   logic [CH_W-1:0]       s2_ch;
   acc_op_e               s2_op;
   logic signed [A_W-1:0] s2_a;
   logic signed [C_W-1:0] s2_c;
   logic signed [BP_W-1:0] s2_bp;

   logic                  s3_valid;
   logic [CH_W-1:0]       s3_ch;
   acc_op_e               s3_op;
   logic signed [C_W-1:0] s3_c;
   logic signed [M_W-1:0] s3_m;

   logic signed [P_W-1:0] acc [NCH];
   logic signed [P_W-1:0] add_a;
   logic signed [P_W-1:0] add_b;
   logic                  add_sub;
   logic signed [P_W-1:0] add_res;
   logic                  add_ovf;

   assign ch_ok = int'(in_ch) < NCH;

   // S1: capture raw operands; a word tagged with a nonexistent channel dies here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_ch    <= '0;
         s1_op    <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_d     <= '0;
         s1_c     <= '0;
      end else begin
         s1_valid <= in_valid && ch_ok;
         s1_ch    <= ch_ok ? in_ch : '0;
         s1_op    <= opmode;
         s1_a     <= a;
         s1_b     <= b;
         s1_d     <= d;
         s1_c     <= c;
      end
   end

   // Pre-adder one bit wider than B so D+B and D-B never truncate
   always_comb begin
      pre_sum = BP_W'(s1_b);
      if (s1_op[PREADD_EN]) begin
         if (s1_op[PREADD_SUB]) begin
            pre_sum = BP_W'(s1_d) - BP_W'(s1_b);
         end else begin
            pre_sum = BP_W'(s1_d) + BP_W'(s1_b);
         end
      end
   end

   // S2: register the pre-adder result alongside the delayed controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_ch    <= '0;
         s2_op    <= OP_LOAD;
         s2_a     <= '0;
         s2_c     <= '0;
         s2_bp    <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_ch    <= s1_ch;
         s2_op    <= acc_op_e'(s1_op[1:0]);
         s2_a     <= s1_a;
         s2_c     <= s1_c;
         s2_bp    <= pre_sum;
      end
   end

   // S3: full-precision signed product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid <= 1'b0;
         s3_ch    <= '0;
         s3_op    <= OP_LOAD;
         s3_c     <= '0;
         s3_m     <= '0;
      end else begin
         s3_valid <= s2_valid;
         s3_ch    <= s2_ch;
         s3_op    <= s2_op;
         s3_c     <= s2_c;
         s3_m     <= M_W'(s2_a) * M_W'(s2_bp);
      end
   end

   // S4 operand select: the accumulator is read here, in the same stage that writes it
   always_comb begin
      add_a   = acc[s3_ch];
      add_b   = P_W'(s3_m);
      add_sub = 1'b0;
      case (s3_op)
         OP_LOAD: add_a   = '0;
         OP_ACC:  add_sub = 1'b0;
         OP_SUB:  add_sub = 1'b1;
         OP_CADD: add_a   = P_W'(s3_c);
         default: add_sub = 1'b0;
      endcase
   end

   dsp_sat_add #(
      .P_W    (P_W),
      .SAT_EN (SAT_EN)
   ) u_sat_add (
      .op_a (add_a),
      .op_b (add_b),
      .sub  (add_sub),
      .res  (add_res),
      .ovf  (add_ovf)
   );

   // S4 result register: P, OUT_CH and OVF hold between valid words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         p         <= '0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= s3_valid;
         if (s3_valid) begin
            out_ch <= s3_ch;
            p      <= add_res;
            ovf    <= add_ovf;
         end
      end
   end

   // Accumulator bank: a clear beats a coinciding write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            acc[i] <= '0;
         end
      end else if (clr) begin
         for (int i = 0; i < NCH; i++) begin
            acc[i] <= '0;
         end
      end else if (s3_valid) begin
         acc[s3_ch] <= add_res;
      end
   end

endmodule

// File: tb/tb_dsp_mac_multich.sv
// tb/tb_dsp_mac_multich.sv - directed bench for the multichannel MAC slice
module tb_dsp_mac_multich;

   localparam int NCH  = 3;
   localparam int CH_W = 2;
   localparam longint PMAX = 64'sd140737488355327;
   localparam longint PMIN = -64'sd140737488355328;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic [CH_W-1:0]     in_ch;
   logic [3:0]          opmode;
   logic signed [17:0]  a;
   logic signed [17:0]  b;
   logic signed [17:0]  d;
   logic signed [47:0]  c;
   logic                clr;

   logic                ov_s, ov_w;
   logic [CH_W-1:0]     och_s, och_w;
   logic signed [47:0]  p_s, p_w;
   logic                ovf_s, ovf_w;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dsp_mac_multich #(
      .A_W(18), .B_W(18), .C_W(48), .P_W(48), .NCH(NCH), .SAT_EN(1'b1)
   ) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .opmode(opmode),
      .a(a), .b(b), .d(d), .c(c), .clr(clr),
      .out_valid(ov_s), .out_ch(och_s), .p(p_s), .ovf(ovf_s)
   );

   dsp_mac_multich #(
      .A_W(18), .B_W(18), .C_W(48), .P_W(48), .NCH(NCH), .SAT_EN(1'b0)
   ) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .opmode(opmode),
      .a(a), .b(b), .d(d), .c(c), .clr(clr),
      .out_valid(ov_w), .out_ch(och_w), .p(p_w), .ovf(ovf_w)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int ch, input logic [3:0] op, input int av, input int bv,
                        input int dv, input longint cv);
      in_valid = 1'b1;
      in_ch    = CH_W'(ch);
      opmode   = op;
      a        = 18'(av);
      b        = 18'(bv);
      d        = 18'(dv);
      c        = 48'(cv);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic expect_s(input string tag, input int ch, input longint pv);
      chk({tag, ".valid"}, longint'(ov_s), 64'sd1);
      chk({tag, ".ch"}, longint'(och_s), longint'(ch));
      chk({tag, ".p"}, longint'(p_s), pv);
      chk({tag, ".ovf"}, longint'(ovf_s), 64'sd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; opmode = '0;
      a = '0; b = '0; d = '0; c = '0; clr = 1'b0;
      repeat (3) step();
      chk("rst.valid", longint'(ov_s), 64'sd0);
      chk("rst.p", longint'(p_s), 64'sd0);
      chk("rst.ch", longint'(och_s), 64'sd0);
      chk("rst.ovf", longint'(ovf_s), 64'sd0);
      chk("rst.p_wrap", longint'(p_w), 64'sd0);
      rst_n = 1'b1;
      step();

      // LOAD 3*4, ACC +2*5, SUB -1*1 on channel 0
      drive(0, 4'b0000, 3, 4, 0, 0); step();
      drive(0, 4'b0001, 2, 5, 0, 0); step();
      drive(0, 4'b0010, 1, 1, 0, 0); step();
      idle(); step();
      expect_s("load", 0, 12); step();
      expect_s("acc", 0, 22); step();
      expect_s("sub", 0, 21); step();
      chk("hold.valid", longint'(ov_s), 64'sd0);
      chk("hold.p", longint'(p_s), 64'sd21);

      // Interleaved channels from a cleared bank
      clr = 1'b1; step(); clr = 1'b0;
      drive(0, 4'b0001, 1, 1, 0, 0); step();
      drive(1, 4'b0001, 1, 2, 0, 0); step();
      drive(0, 4'b0001, 1, 1, 0, 0); step();
      drive(1, 4'b0001, 1, 2, 0, 0); step();
      idle();
      expect_s("il0", 0, 1); step();
      expect_s("il1", 1, 2); step();
      expect_s("il2", 0, 2); step();
      expect_s("il3", 1, 4); step();

      // Pre-adder: (10-3)*-2, (10+3)*-2, then 100 + (10+3)*-2
      drive(2, 4'b1100, -2, 3, 10, 0); step();
      drive(2, 4'b0100, -2, 3, 10, 0); step();
      drive(2, 4'b0111, -2, 3, 10, 100); step();
      idle(); step();
      expect_s("pre_sub", 2, -14); step();
      expect_s("pre_add", 2, -26); step();
      expect_s("cadd", 2, 74); step();

      // Overflow on channel 1: seed at max, +1, then -1
      drive(1, 4'b0011, 0, 0, 0, PMAX); step();
      drive(1, 4'b0001, 1, 1, 0, 0); step();
      drive(1, 4'b0001, -1, 1, 0, 0); step();
      idle(); step();
      expect_s("seed", 1, PMAX);
      chk("seed.p_wrap", longint'(p_w), PMAX);
      step();
      chk("ovf.p_sat", longint'(p_s), PMAX);
      chk("ovf.ovf_sat", longint'(ovf_s), 64'sd1);
      chk("ovf.p_wrap", longint'(p_w), PMIN);
      chk("ovf.ovf_wrap", longint'(ovf_w), 64'sd1);
      step();
      chk("dec.p_sat", longint'(p_s), PMAX - 64'sd1);
      chk("dec.ovf_sat", longint'(ovf_s), 64'sd0);
      chk("dec.p_wrap", longint'(p_w), PMAX);
      chk("dec.ovf_wrap", longint'(ovf_w), 64'sd1);
      step();

      // Out-of-range channel tag, then clear coinciding with a channel-2 write-back
      drive(3, 4'b0001, 1, 1, 0, 0); step();
      drive(2, 4'b0001, 1, 5, 0, 0); step();
      idle(); step(); step();
      chk("bad_ch.valid", longint'(ov_s), 64'sd0);
      clr = 1'b1; step(); clr = 1'b0;
      expect_s("clr_r", 2, 79);
      drive(2, 4'b0001, 1, 1, 0, 0); step();
      idle(); repeat (3) step();
      expect_s("clr_next", 2, 1);
      step();

      // Reset with three words in flight
      drive(0, 4'b0000, 5, 5, 0, 0); step();
      drive(0, 4'b0001, 5, 5, 0, 0); step();
      drive(0, 4'b0001, 5, 5, 0, 0); step();
      idle();
      rst_n = 1'b0; #1;
      chk("mid_rst.valid", longint'(ov_s), 64'sd0);
      chk("mid_rst.p", longint'(p_s), 64'sd0);
      step(); step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post_rst.stale", longint'(ov_s), 64'sd0);
      end
      drive(0, 4'b0001, 2, 3, 0, 0); step();
      idle(); repeat (3) step();
      expect_s("post_rst", 0, 6);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
